minmax_pqueue: RTL and testbench
================================

Name: minmax_pqueue

Overview:
Parametrised double-ended priority queue that holds up to DEPTH {data, tag} entries sorted by tag. Each cycle it can insert an entry and remove either the smallest-tag or the largest-tag entry. Current min and max entries are always visible on the ports. It is the next generation of the checked queue: it adds same-cycle enqueue+dequeue, always-visible min/max peek ports, deterministic tie ordering, and error pulses. It sits between the tag producers and the scheduling logic.

Parameters:
DATA_WIDTH, 32, payload width
TAG_WIDTH, 16, unsigned priority key width
DEPTH, 8, entry count (>=2)
SIZE_W, $clog2(DEPTH+1), width of size_out (derived; not overridden)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
enq_in  input  1  insert {enq_data_in, enq_tag_in} this cycle
enq_data_in  input  DATA_WIDTH  payload to insert
enq_tag_in  input  TAG_WIDTH  key to insert
deq_min_in  input  1  remove smallest-tag entry
deq_max_in  input  1  remove largest-tag entry
data_out  output  DATA_WIDTH  registered dequeue result payload
tag_out  output  TAG_WIDTH  registered dequeue result key
valid_out  output  1  one-cycle pulse: data_out/tag_out valid
min_data_out / min_tag_out  output  DATA_WIDTH / TAG_WIDTH  current smallest entry (peek)
max_data_out / max_tag_out  output  DATA_WIDTH / TAG_WIDTH  current largest entry (peek)
size_out  output  SIZE_W  occupied entries
empty_out  output  1  size_out==0
full_out  output  1  size_out==DEPTH
overflow_out  output  1  pulse: enqueue dropped
underflow_out  output  1  pulse: dequeue on empty
conflict_out  output  1  pulse: deq_min_in and deq_max_in both high
evict_out  output  1  pulse: result is an eviction (PQ_EVICT_EN only)

Behaviour:
- Storage: slot[0..DEPTH-1] registers, kept sorted ascending by tag (unsigned); occupied slots are 0..size-1. min = slot[0], max = slot[size-1]. Peek ports are all zeros when empty.
- Reset (async, immediate, also mid-operation): size 0, all slots 0, every output 0 except empty_out=1.
- Latency: every operation updates the array, size_out and the peek ports on the next clock edge. Dequeue results appear on data_out/tag_out with valid_out=1 in the cycle after the request. data_out/tag_out hold their value until the next dequeue; valid_out is a pulse.
- Insertion position: the new entry goes above all entries with tag <= enq_tag_in. Among equal tags, deq_min therefore returns the oldest entry and deq_max returns the newest.
- Both deq_min_in and deq_max_in high: treated as deq_min only; conflict_out pulses next cycle.
- enq and deq in the same cycle, non-empty: dequeue first, then insert into the reduced set. Size is unchanged. This is legal when full; no overflow.
- enq and deq in the same cycle, empty: enqueue performed (size becomes 1), valid_out=0, underflow_out pulses.
- Deq only, empty: no state change, valid_out=0, underflow_out pulses.
- Enq only, full: handling depends on PQ_EVICT_EN (see Optional Feature).
- All error pulses are registered and last one cycle.
- Implementation: single-cycle parallel compare-and-shift across slots; no multi-cycle FSM.

Optional Feature:
Macro PQ_EVICT_EN.
- Without it: enq-only when full drops the new entry; overflow_out pulses; the array is unchanged.
- With it: enq-only when full performs a top-K replacement. If enq_tag_in > slot[0].tag, slot[0] is ejected and the new entry is inserted. Otherwise the new entry itself is ejected. In both cases the ejected entry appears on data_out/tag_out with valid_out=1 and evict_out=1 next cycle; size stays DEPTH; overflow_out stays 0.
- evict_out is tied 0 when the macro is undefined.

Test Plan (DEPTH=4):
1. Reset; enq (d0,t14), (d1,t35), (d2,t3) -> size 3, min_tag 3, max_tag 35. Then deq_max -> next cycle data 1, tag 35, valid_out 1, size 2.
2. Fill tags 75,12,27,50; enq tag 9 without macro -> overflow_out pulse, size 4, min_tag 12. With PQ_EVICT_EN -> evict_out, tag_out 9, array unchanged.
3. Ties: enq (d10,t5), (d11,t5) -> deq_min gives data 10; deq_max gives data 11.
4. Contents {t3,t9}, deq_min+deq_max in the same cycle -> tag_out 3, conflict_out 1, size 1, min_tag 9. Deq on empty -> underflow_out 1, valid_out 0.
5. Full {10,20,30,40}: enq t25 + deq_max -> tag_out 40; contents {10,20,25,30}; size 4; no overflow. Async reset asserted mid-cycle -> size 0 and empty_out 1 immediately.
6. PQ_EVICT_EN, full {10,20,30,40}: enq t35 -> evicted tag 10, min_tag 20, max_tag 40. Then enq t5 -> evicted tag 5, contents unchanged.

Source files
------------

// File: rtl/minmax_pqueue.sv
// minmax_pqueue: double-ended priority queue of {data, tag} entries kept
// sorted ascending by unsigned tag. One insert plus one min- or max-removal
// per cycle, resolved in a single cycle by parallel per-slot compare-and-shift.
// Optional macro PQ_EVICT_EN: on an insert-only into a full queue, keep the
// DEPTH largest tags and eject the smallest entry instead of dropping.

// One storage slot. Each slot works out its own next value from its own
// entry and its two neighbours. The removal is applied first, giving the
// "after" view a_*, and then the optional insert.
module minmax_pqueue_slot #(
    parameter int EW  = 48,
    parameter int TW  = 16,
    parameter int SW  = 4,
    parameter int IDX = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [EW-1:0] lo_i,        // slot[IDX-1], zero for the bottom slot
    input  logic [EW-1:0] cur_i,       // slot[IDX]
    input  logic [EW-1:0] hi_i,        // slot[IDX+1], zero for the top slot
    input  logic [EW-1:0] new_i,       // entry being inserted
    input  logic [SW-1:0] size_i,      // occupancy before this cycle
    input  logic [SW-1:0] s1_i,        // occupancy after the removal
    input  logic          shift_dn_i,  // remove slot[0]: everything moves down
    input  logic          drop_top_i,  // remove slot[size-1]
    input  logic          ins_i,       // insert new_i into the reduced set
    output logic [EW-1:0] q_o
);
    localparam logic [SW-1:0] IDX_S  = SW'(IDX);
    localparam logic [SW-1:0] IDX_LO = SW'((IDX > 0) ? IDX - 1 : 0);
    localparam bit            FIRST  = (IDX == 0);

    logic [EW-1:0] q_q, q_d;
    logic [EW-1:0] a_cur, a_lo;
    logic [SW-1:0] top_idx;
    logic          le_cur, le_lo;

    assign top_idx = size_i - SW'(1);

    // Removal view, then insertion: an occupied entry whose tag is <= the new
    // tag stays where it is, so equal tags keep arrival order. The first slot
    // above those takes the new entry and the rest move up by one.
    always_comb begin
        a_cur = cur_i;
        if (shift_dn_i)                             a_cur = hi_i;
        else if (drop_top_i && top_idx == IDX_S)    a_cur = '0;
        a_lo = lo_i;
        if (shift_dn_i)                             a_lo = cur_i;
        else if (drop_top_i && top_idx == IDX_LO)   a_lo = '0;
        le_cur = (IDX_S < s1_i) && (a_cur[TW-1:0] <= new_i[TW-1:0]);
        le_lo  = !FIRST && (IDX_LO < s1_i) && (a_lo[TW-1:0] <= new_i[TW-1:0]);
        q_d = a_cur;
        if (ins_i && !le_cur) q_d = (FIRST || le_lo) ? new_i : a_lo;
    end

    // Slot storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

module minmax_pqueue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 16,
    parameter int DEPTH      = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        enq_in,
    input  logic [DATA_WIDTH-1:0]       enq_data_in,
    input  logic [TAG_WIDTH-1:0]        enq_tag_in,
    input  logic                        deq_min_in,
    input  logic                        deq_max_in,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic [TAG_WIDTH-1:0]        tag_out,
    output logic                        valid_out,
    output logic [DATA_WIDTH-1:0]       min_data_out,
    output logic [TAG_WIDTH-1:0]        min_tag_out,
    output logic [DATA_WIDTH-1:0]       max_data_out,
    output logic [TAG_WIDTH-1:0]        max_tag_out,
    output logic [$clog2(DEPTH+1)-1:0]  size_out,
    output logic                        empty_out,
    output logic                        full_out,
    output logic                        overflow_out,
    output logic                        underflow_out,
    output logic                        conflict_out,
    output logic                        evict_out
);
    localparam int              SIZE_W  = $clog2(DEPTH + 1);
    localparam int              EW      = DATA_WIDTH + TAG_WIDTH;
    localparam logic [SIZE_W-1:0] DEPTH_S = SIZE_W'(DEPTH);

    // Entries are packed as {data, tag}; tag occupies the low bits.
    logic [DEPTH-1:0][EW-1:0] slot_q, lo_w, hi_w;
    logic [EW-1:0]            new_e, top_e, res_e;
    logic [SIZE_W-1:0]        size_q, s1, size_d;
    logic                     empty, full, deq_any, dmin, do_deq;
    logic                     shift_dn, drop_top, rm, ins, ev, ev_take, res_vld;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [TAG_WIDTH-1:0]     tag_q;
    logic                     valid_q, ovf_q, unf_q, cfl_q;

    assign new_e   = {enq_data_in, enq_tag_in};
    assign empty   = (size_q == '0);
    assign full    = (size_q == DEPTH_S);
    assign deq_any = deq_min_in | deq_max_in;
    // A simultaneous min+max request is served as a min removal.
    assign dmin    = deq_min_in;
    assign do_deq  = deq_any & ~empty;

`ifdef PQ_EVICT_EN
    // Top-K replacement: keep the DEPTH largest tags.
    assign ev      = enq_in & ~deq_any & full;
    assign ev_take = ev & (enq_tag_in > slot_q[0][TAG_WIDTH-1:0]);
`else
    assign ev      = 1'b0;
    assign ev_take = 1'b0;
`endif

    assign shift_dn = (do_deq & dmin) | ev_take;
    assign drop_top = do_deq & ~dmin;
    assign rm       = shift_dn | drop_top;
    assign s1       = size_q - SIZE_W'(rm);
    assign ins      = enq_in & (s1 < DEPTH_S);
    assign size_d   = s1 + SIZE_W'(ins);
    assign res_vld  = do_deq | ev;

    // Neighbour wiring; the ends see an empty (zero) neighbour.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == 0) begin : g_lo0
            assign lo_w[g] = '0;
        end else begin : g_lon
            assign lo_w[g] = slot_q[g-1];
        end
        if (g == DEPTH - 1) begin : g_hit
            assign hi_w[g] = '0;
        end else begin : g_hin
            assign hi_w[g] = slot_q[g+1];
        end
        minmax_pqueue_slot #(.EW(EW), .TW(TAG_WIDTH), .SW(SIZE_W), .IDX(g)) u_slot (
            .clk_i      (clk_in),
            .rst_i      (rst_in),
            .lo_i       (lo_w[g]),
            .cur_i      (slot_q[g]),
            .hi_i       (hi_w[g]),
            .new_i      (new_e),
            .size_i     (size_q),
            .s1_i       (s1),
            .shift_dn_i (shift_dn),
            .drop_top_i (drop_top),
            .ins_i      (ins),
            .q_o        (slot_q[g])
        );
    end

    // Pick the highest occupied slot; zero when empty.
    always_comb begin
        top_e = '0;
        for (int i = 0; i < DEPTH; i++)
            if (SIZE_W'(i + 1) == size_q) top_e = slot_q[i];
    end

    // Entry leaving the queue this cycle: removed min/max, or the evictee.
    always_comb begin
        res_e = new_e;
        if (do_deq)       res_e = dmin ? slot_q[0] : top_e;
        else if (ev_take) res_e = slot_q[0];
    end

    // Occupancy, result holding register and one-cycle status pulses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            size_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cfl_q   <= 1'b0;
        end else begin
            size_q  <= size_d;
            valid_q <= res_vld;
            if (res_vld) begin
                data_q <= res_e[EW-1:TAG_WIDTH];
                tag_q  <= res_e[TAG_WIDTH-1:0];
            end
            ovf_q <= enq_in & ~ins & ~ev;
            unf_q <= deq_any & empty;
            cfl_q <= deq_min_in & deq_max_in;
        end
    end

`ifdef PQ_EVICT_EN
    logic evt_q;
    // Marks a result that came from a top-K replacement
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) evt_q <= 1'b0;
        else        evt_q <= ev;
    end
    assign evict_out = evt_q;
`else
    assign evict_out = 1'b0;
`endif

    assign data_out      = data_q;
    assign tag_out       = tag_q;
    assign valid_out     = valid_q;
    assign min_data_out  = slot_q[0][EW-1:TAG_WIDTH];
    assign min_tag_out   = slot_q[0][TAG_WIDTH-1:0];
    assign max_data_out  = top_e[EW-1:TAG_WIDTH];
    assign max_tag_out   = top_e[TAG_WIDTH-1:0];
    assign size_out      = size_q;
    assign empty_out     = empty;
    assign full_out      = full;
    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;
    assign conflict_out  = cfl_q;
endmodule

// File: tb/tb_minmax_pqueue.sv
// Bench for minmax_pqueue (DEPTH=4): directed scenarios followed by random
// traffic, all compared against a sorted-queue reference model.
module tb_minmax_pqueue;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int D  = 4;
    localparam int SW = $clog2(D + 1);

    logic          clk = 1'b0, rst = 1'b1;
    logic          enq = 1'b0, dmin = 1'b0, dmax = 1'b0;
    logic [DW-1:0] enq_d = '0;
    logic [TW-1:0] enq_t = '0;
    logic [DW-1:0] data_o, min_d, max_d;
    logic [TW-1:0] tag_o, min_t, max_t;
    logic [SW-1:0] size_o;
    logic          valid_o, empty_o, full_o, ovf_o, unf_o, cfl_o, evt_o;

    minmax_pqueue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D)) dut (
        .clk_in(clk), .rst_in(rst), .enq_in(enq), .enq_data_in(enq_d),
        .enq_tag_in(enq_t), .deq_min_in(dmin), .deq_max_in(dmax),
        .data_out(data_o), .tag_out(tag_o), .valid_out(valid_o),
        .min_data_out(min_d), .min_tag_out(min_t),
        .max_data_out(max_d), .max_tag_out(max_t),
        .size_out(size_o), .empty_out(empty_o), .full_out(full_o),
        .overflow_out(ovf_o), .underflow_out(unf_o),
        .conflict_out(cfl_o), .evict_out(evt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] last_d = '0;
    logic [TW-1:0] last_t = '0;
    logic          e_vld, e_ovf, e_unf, e_cfl, e_evt;
    int            errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Place after every entry with tag <= t (oldest-first among equals).
    function automatic void m_insert(input ent_t e);
        int p = 0;
        while (p < mq.size() && mq[p].t <= e.t) p++;
        mq.insert(p, e);
    endfunction

    function automatic void m_reset();
        mq.delete();
        last_d = '0;
        last_t = '0;
        e_vld = 0; e_ovf = 0; e_unf = 0; e_cfl = 0; e_evt = 0;
    endfunction

    // Reference behaviour of one request cycle.
    function automatic void m_step(input logic en, input logic [DW-1:0] d,
                                   input logic [TW-1:0] t, input logic mn, input logic mx);
        ent_t ne, r;
        ne.d = d; ne.t = t;
        e_vld = 0; e_ovf = 0; e_unf = 0; e_evt = 0;
        e_cfl = mn & mx;
        if (mn | mx) begin
            if (mq.size() == 0) e_unf = 1;
            else begin
                r = mn ? mq.pop_front() : mq.pop_back();
                e_vld = 1; last_d = r.d; last_t = r.t;
            end
        end
        if (en) begin
            if (!(mn | mx) && mq.size() == D) begin
`ifdef PQ_EVICT_EN
                e_evt = 1; e_vld = 1;
                if (t > mq[0].t) begin
                    r = mq.pop_front();
                    m_insert(ne);
                end else r = ne;
                last_d = r.d; last_t = r.t;
`else
                e_ovf = 1;
`endif
            end else m_insert(ne);
        end
    endfunction

    task automatic check_all(input string tag);
        int n = mq.size();
        chk({tag, ":valid"}, 64'(valid_o), 64'(e_vld));
        chk({tag, ":data"},  64'(data_o),  64'(last_d));
        chk({tag, ":tag"},   64'(tag_o),   64'(last_t));
        chk({tag, ":ovf"},   64'(ovf_o),   64'(e_ovf));
        chk({tag, ":unf"},   64'(unf_o),   64'(e_unf));
        chk({tag, ":cfl"},   64'(cfl_o),   64'(e_cfl));
        chk({tag, ":evt"},   64'(evt_o),   64'(e_evt));
        chk({tag, ":size"},  64'(size_o),  64'(n));
        chk({tag, ":empty"}, 64'(empty_o), 64'(n == 0));
        chk({tag, ":full"},  64'(full_o),  64'(n == D));
        chk({tag, ":min_d"}, 64'(min_d), n ? 64'(mq[0].d) : 64'd0);
        chk({tag, ":min_t"}, 64'(min_t), n ? 64'(mq[0].t) : 64'd0);
        chk({tag, ":max_d"}, 64'(max_d), n ? 64'(mq[n-1].d) : 64'd0);
        chk({tag, ":max_t"}, 64'(max_t), n ? 64'(mq[n-1].t) : 64'd0);
    endtask

    // Drive one request cycle, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic en, input logic [DW-1:0] d,
                        input logic [TW-1:0] t, input logic mn, input logic mx);
        enq = en; enq_d = d; enq_t = t; dmin = mn; dmax = mx;
        m_step(en, d, t, mn, mx);
        @(posedge clk); #1;
        enq = 0; dmin = 0; dmax = 0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1;
        #3;
        m_reset();
        check_all("reset");
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [TW-1:0] t0, t1, t2, t3);
        step("fill0", 1, 32'h100, t0, 0, 0);
        step("fill1", 1, 32'h101, t1, 0, 0);
        step("fill2", 1, 32'h102, t2, 0, 0);
        step("fill3", 1, 32'h103, t3, 0, 0);
    endtask

    initial begin
        m_reset();
        #12;
        check_all("reset0");
        rst = 0;
        @(posedge clk); #1;

        // 1: basic ordering and deq_max
        step("t1a", 1, 0, 14, 0, 0);
        step("t1b", 1, 1, 35, 0, 0);
        step("t1c", 1, 2, 3, 0, 0);
        chk("t1:min3", 64'(min_t), 64'd3);
        chk("t1:max35", 64'(max_t), 64'd35);
        step("t1d", 0, 0, 0, 0, 1);
        chk("t1:deq_tag35", 64'(tag_o), 64'd35);
        chk("t1:deq_data1", 64'(data_o), 64'd1);

        // 2: full then enq-only
        do_reset();
        fill(75, 12, 27, 50);
        step("t2", 1, 32'h9, 9, 0, 0);
        chk("t2:min12", 64'(min_t), 64'd12);

        // 3: ties
        do_reset();
        step("t3a", 1, 10, 5, 0, 0);
        step("t3b", 1, 11, 5, 0, 0);
        step("t3c", 1, 12, 5, 0, 0);
        step("t3d", 0, 0, 0, 1, 0);
        chk("t3:oldest", 64'(data_o), 64'd10);
        step("t3e", 0, 0, 0, 0, 1);
        chk("t3:newest", 64'(data_o), 64'd12);

        // 4: conflict and underflow
        do_reset();
        step("t4a", 1, 1, 3, 0, 0);
        step("t4b", 1, 2, 9, 0, 0);
        step("t4c", 0, 0, 0, 1, 1);
        chk("t4:tag3", 64'(tag_o), 64'd3);
        chk("t4:cfl", 64'(cfl_o), 64'd1);
        step("t4d", 0, 0, 0, 1, 0);
        step("t4e", 0, 0, 0, 1, 0);
        chk("t4:unf", 64'(unf_o), 64'd1);
        step("t4f", 1, 7, 44, 0, 1);   // enq+deq on empty
        step("t4g", 1, 8, 2, 1, 0);    // enq+deq, size 1

        // 5: full enq+deq_max, then async reset mid-cycle
        do_reset();
        fill(10, 20, 30, 40);
        step("t5", 1, 32'h25, 25, 0, 1);
        chk("t5:tag40", 64'(tag_o), 64'd40);
        chk("t5:max30", 64'(max_t), 64'd30);
        #2;
        rst = 1;
        #1;
        m_reset();
        check_all("t5:async");
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;

`ifdef PQ_EVICT_EN
        // 6: top-K replacement
        fill(10, 20, 30, 40);
        step("t6a", 1, 32'h35, 35, 0, 0);
        chk("t6:ev10", 64'(tag_o), 64'd10);
        step("t6b", 1, 32'h5, 5, 0, 0);
        chk("t6:ev5", 64'(tag_o), 64'd5);
        do_reset();
`endif

        // Random traffic; narrow tag range forces many ties.
        for (int i = 0; i < 600; i++) begin
            int op = int'($urandom_range(0, 9));
            logic e = (op < 6);
            logic mn = (op >= 4 && op <= 6) || op == 9;
            logic mx = (op == 7 || op == 8 || op == 9);
            step("rnd", e, $urandom, TW'($urandom_range(0, 15)), mn, mx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
